// File: rtl/issue_unit.sv
// In-order issue stage: pops the instruction queue, allocates a reservation station and renames rd.
// Define ISSUE_STATS_EN to add the issued_cnt / stall_cnt statistics outputs.
module issue_unit #(
   parameter int unsigned NUM_ADD = 3,
   parameter int unsigned NUM_MUL = 2
) (
   input  logic               CLK,
   input  logic               CLR,
   input  logic               vazio,
   input  logic               q_adc,
   input  logic [15:0]        instrIn,
   output logic               rtr,
   input  logic [NUM_ADD-1:0] add_busy,
   input  logic [NUM_MUL-1:0] mul_busy,
   output logic [2:0]         rf_ra,
   output logic [2:0]         rf_rb,
   input  logic [15:0]        rf_da,
   input  logic [15:0]        rf_db,
   input  logic               cdb_valid,
   input  logic [2:0]         cdb_tag,
   input  logic [15:0]        cdb_data,
   output logic               rs_we,
   output logic [2:0]         rs_tag,
   output logic [1:0]         rs_op,
   output logic [15:0]        rs_vj,
   output logic [15:0]        rs_vk,
   output logic [2:0]         rs_qj,
   output logic [2:0]         rs_qk,
   output logic               busy_o
`ifdef ISSUE_STATS_EN
   ,
   output logic [15:0]        issued_cnt,
   output logic [15:0]        stall_cnt
`endif
);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StFetch    = 2'd1,
      StDispatch = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] ir_q;
   logic [2:0]  rst_q [8];

   logic [3:0]  ir_opc;
   logic [2:0]  ir_rd, ir_rs, ir_rt;
   logic        op_valid, is_mul;
   logic        free_found;
   logic [2:0]  free_tag;
   logic        pop_ok;
   logic [2:0]  tag_j, tag_k;
   logic        unused_ir;

   assign ir_opc    = ir_q[15:12];
   assign ir_rd     = ir_q[11:9];
   assign ir_rs     = ir_q[8:6];
   assign ir_rt     = ir_q[5:3];
   assign unused_ir = ^ir_q[2:0];
   assign op_valid  = (ir_opc[3:2] == 2'b00);
   assign is_mul    = ir_opc[1];
   assign pop_ok    = !vazio && !q_adc;
   assign tag_j     = rst_q[ir_rs];
   assign tag_k     = rst_q[ir_rt];
   assign busy_o    = (state_q != StIdle);

   // Scan from the top down so the lowest free index is the one left standing.
   always_comb begin
      free_found = 1'b0;
      free_tag   = 3'd0;
      if (!is_mul) begin
         for (int i = int'(NUM_ADD) - 1; i >= 0; i--) begin
            if (!add_busy[i]) begin
               free_found = 1'b1;
               free_tag   = 3'(i + 1);
            end
         end
      end else begin
         for (int i = int'(NUM_MUL) - 1; i >= 0; i--) begin
            if (!mul_busy[i]) begin
               free_found = 1'b1;
               free_tag   = 3'(int'(NUM_ADD) + i + 1);
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         ir_q <= 16'd0;
      end else if (state_q == StFetch) begin
         ir_q <= instrIn;
      end
   end

   always_comb begin
      state_d = state_q;
      rtr     = 1'b0;
      rf_ra   = 3'd0;
      rf_rb   = 3'd0;
      rs_we   = 1'b0;
      rs_tag  = 3'd0;
      rs_op   = 2'd0;
      rs_vj   = 16'd0;
      rs_vk   = 16'd0;
      rs_qj   = 3'd0;
      rs_qk   = 3'd0;
      unique case (state_q)
         StIdle: begin
            rtr = pop_ok;
            if (pop_ok) state_d = StFetch;
         end
         StFetch: begin
            state_d = StDispatch;
         end
         StDispatch: begin
            rf_ra = ir_rs;
            rf_rb = ir_rt;
            if (!op_valid) begin
               state_d = StIdle;
            end else if (free_found) begin
               rs_we  = 1'b1;
               rs_tag = free_tag;
               rs_op  = ir_opc[1:0];
               // Operands see the rename table before this cycle's rename of rd.
               if (tag_j == 3'd0) begin
                  rs_vj = rf_da;
               end else if (cdb_valid && cdb_tag == tag_j) begin
                  rs_vj = cdb_data;
               end else begin
                  rs_qj = tag_j;
               end
               if (tag_k == 3'd0) begin
                  rs_vk = rf_db;
               end else if (cdb_valid && cdb_tag == tag_k) begin
                  rs_vk = cdb_data;
               end else begin
                  rs_qk = tag_k;
               end
               rtr     = pop_ok;
               state_d = pop_ok ? StFetch : StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      rtr = rtr && CLR;
   end

   // Rename of rd takes precedence over a CDB clear of the same register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         for (int r = 0; r < 8; r++) begin
            rst_q[r] <= 3'd0;
         end
      end else begin
         for (int r = 0; r < 8; r++) begin
            if (rs_we && ir_rd == 3'(r)) begin
               rst_q[r] <= rs_tag;
            end else if (cdb_valid && cdb_tag != 3'd0 && rst_q[r] == cdb_tag) begin
               rst_q[r] <= 3'd0;
            end
         end
      end
   end

`ifdef ISSUE_STATS_EN
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         issued_cnt <= 16'd0;
         stall_cnt  <= 16'd0;
      end else begin
         if (rs_we) issued_cnt <= issued_cnt + 16'd1;
         if (state_q == StDispatch && op_valid && !free_found) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
